// File: rtl/csa_seq_adder_ctrl_if.sv
// Handshake/bus bundle for the sequential carry-select adder controller.
// Master drives operands and result acceptance; slave is the controller.
interface csa_seq_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             COUT;
  logic             OVF;

  modport master (
    output in_valid, A, B, CIN, out_ready,
    input  in_ready, out_valid, S, COUT, OVF
  );

  modport slave (
    input  in_valid, A, B, CIN, out_ready,
    output in_ready, out_valid, S, COUT, OVF
  );
endinterface

// File: rtl/csa_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit carry-select slice processes
// a nibble per cycle, LSB first, with the carry held in a register.
module csa_seq_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  csa_seq_adder_ctrl_if.slave bus
);
  localparam int unsigned SLICES = WIDTH / 4;
  localparam int unsigned IdxW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(SLICES - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("csa_seq_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_s;
  logic [IdxW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [4:0] w_sum0;
  logic [4:0] w_sum1;
  logic [3:0] w_low0;
  logic [3:0] w_low1;
  logic [3:0] w_nib;
  logic       w_cout;
  logic       w_c3;

  assign w_a_nib = r_op_a[4*r_idx +: 4];
  assign w_b_nib = r_op_b[4*r_idx +: 4];

  // Both carry hypotheses are formed in parallel; the carry register picks one.
  assign w_sum0 = {1'b0, w_a_nib} + {1'b0, w_b_nib};
  assign w_sum1 = {1'b0, w_a_nib} + {1'b0, w_b_nib} + 5'd1;
  // Lower three bits of each hypothesis give the carry into bit 3 (for OVF).
  assign w_low0 = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]};
  assign w_low1 = {1'b0, w_a_nib[2:0]} + {1'b0, w_b_nib[2:0]} + 4'd1;

  assign w_nib  = r_carry ? w_sum1[3:0] : w_sum0[3:0];
  assign w_cout = r_carry ? w_sum1[4]   : w_sum0[4];
  assign w_c3   = r_carry ? w_low1[3]   : w_low0[3];

  // Controller FSM with registered result, carry and slice index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_op_a  <= bus.A;
            r_op_b  <= bus.B;
            r_carry <= bus.CIN;
            r_idx   <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_s[4*r_idx +: 4] <= w_nib;
          r_carry           <= w_cout;
          if (r_idx == LastIdx) begin
            r_cout  <= w_cout;
            r_ovf   <= w_c3 ^ w_cout;
            r_idx   <= '0;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.S         = r_s;
  assign bus.COUT      = r_cout;
  assign bus.OVF       = r_ovf;
endmodule
